// File: rtl/v_disp_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Includes segment patterns (active-low a..g), converter state encoding and a power-of-ten helper.
package v_disp_pkg;

  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;
  localparam logic [0:6] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } conv_state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/v_bin2bcd_seq.sv
// Sequential shift-add-3 binary-to-BCD converter: one bit per clock, WIDTH shift cycles
// followed by a single LATCH cycle in which done is high and bcd holds the result.
module v_bin2bcd_seq
  import v_disp_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int NDIG  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*NDIG-1:0]   bcd
);

  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(WIDTH + 1);

  conv_state_t      r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]    r_bcd;
  logic [BW-1:0]    w_adj;
  logic             w_start;

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < NDIG; i++)
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    return r;
  endfunction

  assign w_start = (r_state == IDLE) && start;
  assign w_adj   = add3(r_bcd);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = SHIFT;
      SHIFT:   if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = LATCH;
      LATCH:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_start) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
      end else if (r_state == SHIFT) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == LATCH) r_busy <= 1'b0;
    end
  end

  // Shift stage: adjust every nibble, then shift {bcd, bin} left; MSB of bcd falls off.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_bin <= bin;
      r_bcd <= '0;
    end else if (r_state == SHIFT) begin
      r_bcd <= {w_adj[BW-2:0], r_bin[WIDTH-1]};
      r_bin <= {r_bin[WIDTH-2:0], 1'b0};
    end
  end

  assign busy = r_busy;
  assign done = (r_state == LATCH);
  assign bcd  = r_bcd;

endmodule

// File: rtl/v_disp_scan_n.sv
// Multiplexed common-anode display driver: converts a binary value to BCD on load and
// scans NDIG digits with leading-zero blanking and an all-dash overflow indication.
module v_disp_scan_n
  import v_disp_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int WIDTH    = 14,
  parameter int REFRESH  = 100000,
  parameter int BLANK_LZ = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic             ovf,
  output logic [0:6]       seg,
  output logic [0:NDIG-1]  an
);

  localparam int          PW      = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam int          IW      = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [63:0] OVF_LIM = pow10(NDIG);

  logic              w_busy, w_done, w_accept;
  logic [4*NDIG-1:0] w_bcd;
  logic              r_ovf_pend, r_ovf;
  logic [3:0]        r_dig [NDIG];
  logic [PW-1:0]     r_presc;
  logic [IW-1:0]     r_idx_p0;
  logic [0:6]        r_seg_p1, w_seg;
  logic [0:NDIG-1]   r_an_p1, w_an;
  logic [NDIG-1:0]   w_lz;
  logic              w_run;

  function automatic logic [0:6] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  assign w_accept = load && !w_busy;

  v_bin2bcd_seq #(.WIDTH(WIDTH), .NDIG(NDIG)) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (w_accept),
    .bin   (value),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  // Display digits only change on done, so a partial conversion is never visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
      for (int i = 0; i < NDIG; i++) r_dig[i] <= 4'd0;
    end else begin
      if (w_accept) r_ovf_pend <= (64'(value) >= OVF_LIM);
      if (w_done) begin
        r_ovf <= r_ovf_pend;
        for (int i = 0; i < NDIG; i++) r_dig[i] <= w_bcd[4*(NDIG-1-i) +: 4];
      end
    end
  end

  // Stage p0: prescaler and scan index.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc  <= '0;
      r_idx_p0 <= '0;
    end else if (r_presc == PW'(REFRESH - 1)) begin
      r_presc  <= '0;
      r_idx_p0 <= (r_idx_p0 == IW'(NDIG - 1)) ? '0 : r_idx_p0 + IW'(1);
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_comb begin
    w_run = 1'b1;
    w_lz  = '0;
    for (int i = 0; i < NDIG; i++) begin
      w_run   = w_run && (r_dig[i] == 4'd0);
      w_lz[i] = w_run;
    end
    if (r_ovf)
      w_seg = SEG_DASH;
    else if ((BLANK_LZ != 0) && (r_idx_p0 != IW'(NDIG - 1)) && w_lz[r_idx_p0])
      w_seg = SEG_BLANK;
    else
      w_seg = seg_decode(r_dig[r_idx_p0]);
    for (int i = 0; i < NDIG; i++) w_an[i] = (r_idx_p0 != IW'(i));
  end

  // Stage p1: registered segment and anode drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg_p1 <= SEG_BLANK;
      r_an_p1  <= '1;
    end else begin
      r_seg_p1 <= w_seg;
      r_an_p1  <= w_an;
    end
  end

  assign busy = w_busy;
  assign ovf  = r_ovf;
  assign seg  = r_seg_p1;
  assign an   = r_an_p1;

endmodule

// File: tb/tb_v_disp_scan_n.sv
// Directed bench for v_disp_scan_n: two instances (blanking on/off) share all inputs,
// every displayed frame is compared digit by digit against hand-computed segment codes.
`timescale 1ns/1ps
module tb_v_disp_scan_n;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] SB = 7'b1111111;
  localparam logic [6:0] SD = 7'b1111110;

  typedef logic [0:3][6:0] frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [13:0] value = '0;
  logic        busy, ovf, busy_nb, ovf_nb;
  logic [0:6]  seg, seg_nb;
  logic [0:3]  an, an_nb;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  v_disp_scan_n #(.NDIG(4), .WIDTH(14), .REFRESH(4), .BLANK_LZ(1)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy), .ovf(ovf), .seg(seg), .an(an)
  );

  v_disp_scan_n #(.NDIG(4), .WIDTH(14), .REFRESH(4), .BLANK_LZ(0)) dut_nb (
    .clk(clk), .rst(rst), .value(value), .load(load),
    .busy(busy_nb), .ovf(ovf_nb), .seg(seg_nb), .an(an_nb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_load(input logic [13:0] v);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic check_frame(input string tag, input frame_t e, input frame_t enb);
    logic [0:3] prev, ea;
    logic       found;
    int         t, d;
    prev  = an;
    t     = 0;
    found = 1'b0;
    while (!found && t < 40) begin
      @(negedge clk);
      t++;
      found = (an == 4'b0111) && (prev != 4'b0111);
      prev  = an;
    end
    check({tag, "_sync"}, found, 1);
    if (found) begin
      for (int c = 0; c < 16; c++) begin
        d  = c / 4;
        ea = ~(4'b1000 >> d);
        check($sformatf("%s_an_c%0d", tag, c), an, ea);
        check($sformatf("%s_seg_c%0d", tag, c), seg, e[d]);
        check($sformatf("%s_segnb_c%0d", tag, c), seg_nb, enb[d]);
        if (c < 15) @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_ovf", ovf, 0);
    check("rst_seg", seg, SB);
    check("rst_an", an, 4'b1111);
    check("rst_seg_nb", seg_nb, SB);
    check("rst_an_nb", an_nb, 4'b1111);
    rst = 1'b0;
    check_frame("zero", {SB, SB, SB, S0}, {S0, S0, S0, S0});

    do_load(14'd1234);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("busy_len", n, 15);
    check("ovf_1234", ovf, 0);
    check_frame("v1234", {S1, S2, S3, S4}, {S1, S2, S3, S4});

    do_load(14'd7);
    wait_idle("v7");
    check_frame("v7", {SB, SB, SB, S7}, {S0, S0, S0, S7});

    do_load(14'd1005);
    wait_idle("v1005");
    check_frame("v1005", {S1, S0, S0, S5}, {S1, S0, S0, S5});

    do_load(14'd12000);
    repeat (14) @(negedge clk);
    check("ovf_busy_last", busy, 1);
    check("ovf_not_yet", ovf, 0);
    @(negedge clk);
    check("ovf_busy_done", busy, 0);
    check("ovf_set", ovf, 1);
    check("ovf_set_nb", ovf_nb, 1);
    check_frame("v12000", {SD, SD, SD, SD}, {SD, SD, SD, SD});

    do_load(14'd42);
    wait_idle("v42");
    check("ovf_clr", ovf, 0);
    check_frame("v42", {SB, SB, S4, S2}, {S0, S0, S4, S2});

    do_load(14'd1234);
    repeat (4) @(negedge clk);
    check("rej_busy5", busy, 1);
    value = 14'd9999;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    wait_idle("rej");
    check_frame("rej1234", {S1, S2, S3, S4}, {S1, S2, S3, S4});

    do_load(14'd500);
    wait_idle("v500");
    value = 14'd56;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    check("fall_accept", busy, 1);
    wait_idle("v56");
    check_frame("v56", {SB, SB, S5, S6}, {S0, S0, S5, S6});

    do_load(14'd8888);
    repeat (5) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_seg", seg, SB);
    check("mid_rst_an", an, 4'b1111);
    rst = 1'b0;
    check_frame("mid_zero", {SB, SB, SB, S0}, {S0, S0, S0, S0});
    repeat (20) @(negedge clk);
    check("mid_stay_idle", busy, 0);
    check_frame("mid_zero2", {SB, SB, SB, S0}, {S0, S0, S0, S0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
